// File: rtl/fetch_stage.sv
// LEGv8 IF stage: owns the fetch PC, addresses the instruction ROM and
// registers the fetched word into IF/ID with stall/flush/redirect control.
module fetch_stage #(
  parameter int unsigned   N   = 64,
  parameter int unsigned   IW  = 32,
  parameter int unsigned   AW  = 7,
  parameter logic [IW-1:0] NOP = 32'h8b1f03ff
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          PCSrc,
  input  logic [N-1:0]  PCBranch,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_q,
  output logic [N-1:0]  pc_F,
  output logic [IW-1:0] instr_D,
  output logic [N-1:0]  pc_D,
  output logic          valid_D,
  output logic [31:0]   fetch_count
);

  localparam logic [N-1:0] PC_STEP = N'(4);

  logic [N-1:0]  r_pc_F;
  logic [IW-1:0] r_instr_D;
  logic [N-1:0]  r_pc_D;
  logic          r_valid_D;
  logic [31:0]   r_fetch_count;
  logic [N-1:0]  w_pc_next;
  logic          w_capture;

  // Redirect outranks stall so a taken branch is never lost behind a hazard.
  always_comb begin
    w_pc_next = r_pc_F;
    if (PCSrc)
      w_pc_next = {PCBranch[N-1:2], 2'b00};
    else if (!stall)
      w_pc_next = r_pc_F + PC_STEP;
  end

  assign w_capture = !flush && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_pc_F <= '0;
    else
      r_pc_F <= w_pc_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_D <= NOP;
      r_pc_D    <= '0;
      r_valid_D <= 1'b0;
    end else if (flush) begin
      r_instr_D <= NOP;
      r_pc_D    <= '0;
      r_valid_D <= 1'b0;
    end else if (w_capture) begin
      r_instr_D <= imem_q;
      r_pc_D    <= r_pc_F;
      r_valid_D <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_fetch_count <= '0;
    else if (w_capture && (r_fetch_count != '1))
      r_fetch_count <= r_fetch_count + 32'd1;
  end

  assign imem_addr   = r_pc_F[AW+1:2];
  assign pc_F        = r_pc_F;
  assign instr_D     = r_instr_D;
  assign pc_D        = r_pc_D;
  assign valid_D     = r_valid_D;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/flush/redirect traffic, all checked against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP_W = 32'h8b1f03ff;

  logic        clk = 1'b0;
  logic        reset, stall, flush, PCSrc;
  logic [63:0] PCBranch;
  logic [6:0]  imem_addr;
  logic [31:0] imem_q;
  logic [63:0] pc_F, pc_D;
  logic [31:0] instr_D, fetch_count;
  logic        valid_D;

  logic [31:0] rom [128];

  // Reference model state
  logic [63:0] m_pc, m_pcd;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.N(64), .IW(32), .AW(7), .NOP(32'h8b1f03ff)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .PCSrc(PCSrc),
    .PCBranch(PCBranch), .imem_addr(imem_addr), .imem_q(imem_q),
    .pc_F(pc_F), .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign imem_q = rom[imem_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] word_addr;
    word_addr = (m_pc / 4) % 128;
    check({tag, ".pc_F"},    pc_F, m_pc);
    check({tag, ".addr"},    {57'd0, imem_addr}, word_addr);
    check({tag, ".instr_D"}, {32'd0, instr_D}, {32'd0, m_instr});
    check({tag, ".pc_D"},    pc_D, m_pcd);
    check({tag, ".valid_D"}, {63'd0, valid_D}, {63'd0, m_valid});
    check({tag, ".count"},   {32'd0, fetch_count}, {32'd0, m_cnt});
  endtask

  task automatic model_reset();
    m_pc = 0; m_pcd = 0; m_instr = NOP_W; m_valid = 1'b0; m_cnt = 0;
  endtask

  // One clock: apply inputs, advance model by the fetch rules, compare after the edge.
  task automatic step(input logic st, input logic fl, input logic ps,
                      input logic [63:0] br, input string tag);
    logic [63:0] nxt_pc;
    stall = st; flush = fl; PCSrc = ps; PCBranch = br;
    if (ps)       nxt_pc = br - (br % 4);
    else if (st)  nxt_pc = m_pc;
    else          nxt_pc = m_pc + 64'd4;
    if (fl) begin
      m_instr = NOP_W; m_pcd = 0; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = rom[(m_pc / 4) % 128];
      m_pcd   = m_pc;
      m_valid = 1'b1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    m_pc = nxt_pc;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int k = 0; k < 128; k++) rom[k] = 32'hA000_0000 + k;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; PCSrc = 1'b0; PCBranch = '0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Free run to pc 8
    step(0, 0, 0, 0, "run0");
    step(0, 0, 0, 0, "run1");
    check("run1.instr_lit", {32'd0, instr_D}, 64'hA000_0001);

    // Stall three cycles
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, "stall");
      check("stall.pc_lit", pc_F, 64'd8);
    end
    step(0, 0, 0, 0, "release");
    check("release.instr_lit", {32'd0, instr_D}, 64'hA000_0002);
    step(0, 0, 0, 0, "run2");
    step(0, 0, 0, 0, "run3");

    // Redirect with flush at pc 20
    step(0, 1, 1, 64'h40, "redir");
    check("redir.pc_lit", pc_F, 64'h40);
    step(0, 0, 0, 0, "target");
    check("target.instr_lit", {32'd0, instr_D}, 64'hA000_0010);

    // Redirect beats stall, misaligned target
    step(1, 0, 1, 64'h1F, "stall_redir");
    check("stall_redir.pc_lit", pc_F, 64'h1C);

    // ROM address wrap at 512 bytes
    step(0, 0, 1, 64'h1FC, "to1fc");
    check("to1fc.addr_lit", {57'd0, imem_addr}, 64'd127);
    step(0, 0, 0, 0, "wrap512");
    check("wrap512.addr_lit", {57'd0, imem_addr}, 64'd0);
    check("wrap512.pc_lit", pc_F, 64'h200);

    // PC wraps modulo 2^64; redirect without flush captures sequential word
    step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, "tomax");
    step(0, 0, 0, 0, "pcwrap");
    check("pcwrap.pc_lit", pc_F, 64'd0);

    // Async reset mid-cycle
    step(0, 0, 1, 64'h30, "to30");
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    check_all("rst_held");
    reset = 1'b0;
    step(0, 0, 0, 0, "post_rst");

    // Random traffic over a randomized ROM
    for (int k = 0; k < 128; k++) rom[k] = $urandom;
    for (int i = 0; i < 400; i++) begin
      logic [63:0] br;
      br = {$urandom, $urandom};
      if ($urandom_range(0, 1)) br = br % 1024;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, br, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the pipelined LEGv8 core, sitting directly upstream of the instruction ROM.
- Holds the PC and drives the ROM word address.
- Captures the combinational ROM output into the IF/ID pipeline register.
- Handles stall, branch redirect and flush, and keeps a count of valid fetches for bring-up.

Parameters:
- N, 64, PC / address datapath width.
- IW, 32, instruction width (matches ROM word width).
- AW, 7, ROM word-address width (128 words).
- NOP, 32'h8b1f03ff, bubble encoding (ADD XZR,XZR,XZR) loaded into IF/ID on flush/reset.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- stall  input  1  hazard unit: hold PC and IF/ID.
- flush  input  1  kill IF/ID contents (wrong-path instruction).
- PCSrc  input  1  taken branch from later stage: redirect PC.
- PCBranch  input  N  redirect target byte address.
- imem_addr  output  AW  ROM word address = pc_F[AW+1:2].
- imem_q  input  IW  ROM read data (combinational, same cycle).
- pc_F  output  N  current fetch PC.
- instr_D  output  IW  IF/ID instruction.
- pc_D  output  N  IF/ID PC of that instruction.
- valid_D  output  1  IF/ID holds a real (non-bubble) instruction.
- fetch_count  output  32  number of valid instructions latched into IF/ID, saturating.

Behaviour:
- Reset (async, immediate, any cycle): pc_F=0, pc_D=0, instr_D=NOP, valid_D=0, fetch_count=0.
- imem_addr is purely combinational from pc_F. Bits pc_F[1:0] and bits above AW+1 are ignored, so the ROM address wraps every 512 bytes.
- Next-PC priority, evaluated each edge:
  1. PCSrc=1: pc_F <= {PCBranch[N-1:2],2'b00}. Taken regardless of stall.
  2. else stall=1: pc_F holds.
  3. else: pc_F <= pc_F+4, modulo 2^N (wraps silently).
- IF/ID priority, evaluated each edge:
  1. flush=1: instr_D<=NOP, pc_D<=0, valid_D<=0. Flush wins over stall.
  2. else stall=1: instr_D, pc_D and valid_D hold.
  3. else: instr_D<=imem_q, pc_D<=pc_F, valid_D<=1.
- PCSrc does not itself clear IF/ID; the hazard unit asserts flush alongside it.
  - PCSrc=1, flush=0, stall=0: IF/ID captures the current (sequential) word and the PC redirects.
- fetch_count increments by 1 on every edge where case 3 of the IF/ID update occurs. It saturates at 32'hFFFFFFFF and never wraps.
- Latency:
  - Instruction at PC p is visible on instr_D one cycle after pc_F=p, absent stall/flush.
  - A redirect is visible on pc_F one cycle after PCSrc is sampled; the target instruction reaches instr_D one cycle later.
- Misaligned PCBranch: low two bits forced to zero, no error flag.
- Reset deasserted mid-program: fetch restarts at PC 0 on the first edge after release. No partial state is retained.

Test Plan:
- Reset, then 4 free-running cycles with ROM word k = 32'hA000_0000+k -> pc_F steps 0,4,8,12,16; instr_D = A0000000..A0000003, pc_D = 0,4,8,12; valid_D=1 from the first edge; fetch_count=4.
- At pc_F=8, hold stall for 3 cycles -> pc_F stays 8; instr_D stays A0000001 with pc_D=4; fetch_count unchanged. Release -> next edge instr_D=A0000002, pc_F=12.
- At pc_F=20, assert PCSrc=1, flush=1, PCBranch=0x40 for 1 cycle -> pc_F=0x40, instr_D=NOP, valid_D=0, pc_D=0. Next edge instr_D=A0000010, pc_D=0x40.
- stall=1 together with PCSrc=1, PCBranch=0x1F -> pc_F=0x1C (redirect beats stall, low bits cleared); IF/ID holds.
- pc_F=0x1FC, free run -> imem_addr=127 then 0 at pc_F=0x200; pc_F keeps counting (0x200, not 0).
- Assert reset asynchronously mid-cycle while pc_F=0x30, valid_D=1 -> all outputs return to reset values before the next edge. After release, fetch resumes from PC 0.
